// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: LSD-first words of DIGITS x DIGIT bits, add or
// subtract per word, stall tolerant, with end-of-word carry/borrow and signed overflow.
module serial_add_sub #(
    parameter int DIGIT  = 1,
    parameter int DIGITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic             sub,
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    output logic [DIGIT-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             err
);

    localparam int CW = (DIGITS > 2) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] ZERO_IDX = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_IDX  = CW'(1);
    localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // One digit of ripple addition: returns {carry_out, sum_digit}.
    function automatic logic [DIGIT:0] digit_add(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             cin
    );
        digit_add = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
    endfunction

    logic [0:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic          carry_r;
    logic          mode_r;

    logic             start_s;
    logic             cont_s;
    logic             drop_s;
    logic             abort_s;
    logic             proc_s;
    logic             mode_eff_s;
    logic             cin_s;
    logic [CW-1:0]    idx_s;
    logic [DIGIT-1:0] b_eff_s;
    logic [DIGIT:0]   sum_full_s;
    logic             c_next_s;
    logic             last_s;
    logic             ovf_s;

    // Classify the incoming digit against the current framing state.
    always_comb begin
        start_s = in_valid & in_first;
        cont_s  = 1'b0;
        drop_s  = 1'b0;
        abort_s = 1'b0;
        case (state_r)
            IDLE: begin
                drop_s = in_valid & ~in_first;
            end
            BUSY: begin
                cont_s  = in_valid & ~in_first;
                abort_s = start_s;
            end
            default: begin
                drop_s = in_valid & ~in_first;
            end
        endcase
        proc_s = start_s | cont_s;
    end

    // Digit datapath; a new word takes its mode and carry-in straight from sub.
    always_comb begin
        if (start_s) begin
            mode_eff_s = sub;
            cin_s      = sub;
            idx_s      = ZERO_IDX;
        end else begin
            mode_eff_s = mode_r;
            cin_s      = carry_r;
            idx_s      = cnt_r;
        end
        b_eff_s    = b ^ {DIGIT{mode_eff_s}};
        sum_full_s = digit_add(a, b_eff_s, cin_s);
        c_next_s   = sum_full_s[DIGIT];
        last_s     = proc_s & (idx_s == LAST_IDX);
        ovf_s      = (a[DIGIT-1] ^ b_eff_s[DIGIT-1] ^ sum_full_s[DIGIT-1]) ^ c_next_s;
    end

    // Framing state, digit counter, running carry and latched mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= ZERO_IDX;
            carry_r <= 1'b0;
            mode_r  <= 1'b0;
        end else if (proc_s) begin
            carry_r <= c_next_s;
            mode_r  <= mode_eff_s;
            if (last_s) begin
                state_r <= IDLE;
                cnt_r   <= ZERO_IDX;
            end else begin
                state_r <= BUSY;
                cnt_r   <= idx_s + ONE_IDX;
            end
        end else begin
            state_r <= state_r;
            cnt_r   <= cnt_r;
            carry_r <= carry_r;
            mode_r  <= mode_r;
        end
    end

    // Registered outputs; word flags are forced low outside their qualifying cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            sum       <= {DIGIT{1'b0}};
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= proc_s;
            out_first <= start_s;
            out_last  <= last_s;
            sum       <= proc_s ? sum_full_s[DIGIT-1:0] : {DIGIT{1'b0}};
            carry_out <= last_s & c_next_s;
            overflow  <= last_s & ovf_s;
            err       <= drop_s | abort_s;
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: a word-level arithmetic model checks two instances
// (DIGIT=1/DIGITS=8 and DIGIT=4/DIGITS=2) every cycle, plus literal word results.
module tb_serial_add_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid_d [2];
    logic       in_first_d [2];
    logic       sub_d      [2];
    logic [0:0] a0, b0, sum0;
    logic [3:0] a1, b1, sum1;
    logic       out_valid_d [2];
    logic       out_first_d [2];
    logic       out_last_d  [2];
    logic       carry_d     [2];
    logic       ovf_d       [2];
    logic       err_d       [2];

    int tests  = 0;
    int failed = 0;

    serial_add_sub #(.DIGIT(1), .DIGITS(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_d[0]), .in_first(in_first_d[0]),
        .sub(sub_d[0]), .a(a0), .b(b0), .out_valid(out_valid_d[0]),
        .out_first(out_first_d[0]), .out_last(out_last_d[0]), .sum(sum0),
        .carry_out(carry_d[0]), .overflow(ovf_d[0]), .err(err_d[0])
    );

    serial_add_sub #(.DIGIT(4), .DIGITS(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_d[1]), .in_first(in_first_d[1]),
        .sub(sub_d[1]), .a(a1), .b(b1), .out_valid(out_valid_d[1]),
        .out_first(out_first_d[1]), .out_last(out_last_d[1]), .sum(sum1),
        .carry_out(carry_d[1]), .overflow(ovf_d[1]), .err(err_d[1])
    );

    // model state: word operands collected so far, position within word
    bit          m_busy [2];
    int          m_idx  [2];
    bit          m_mode [2];
    logic [63:0] m_a    [2];
    logic [63:0] m_b    [2];
    bit          e_valid [2], e_first [2], e_last [2], e_carry [2], e_ovf [2], e_err [2];
    logic [3:0]  e_sum   [2];

    // per-word logs: DUT-reassembled results and model results
    logic [7:0]  lw [2][64];
    logic [7:0]  mw [2][64];
    bit          lc [2][64];
    bit          lo [2][64];
    int          ln [2];
    int          mn [2];
    logic [63:0] acc [2];
    int          pos [2];

    function automatic int dig_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int nd_of(input int d);
        return (d == 0) ? 8 : 2;
    endfunction

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic model_step(input int d);
        int dig, nd, w;
        logic [63:0] mask, dmask, av, bv, beff, r;
        bit v, f, sb, proc, sa, sbb, sr;
        dig   = dig_of(d);
        nd    = nd_of(d);
        w     = dig * nd;
        mask  = (64'd1 << w) - 64'd1;
        dmask = (64'd1 << dig) - 64'd1;
        v  = in_valid_d[d];
        f  = in_first_d[d];
        sb = sub_d[d];
        av = (d == 0) ? {63'd0, a0} : {60'd0, a1};
        bv = (d == 0) ? {63'd0, b0} : {60'd0, b1};
        e_valid[d] = 0; e_first[d] = 0; e_last[d] = 0;
        e_carry[d] = 0; e_ovf[d] = 0; e_err[d] = 0; e_sum[d] = 4'd0;
        proc = 0;
        if (rst) begin
            m_busy[d] = 0; m_idx[d] = 0; m_mode[d] = 0;
        end else if (v) begin
            if (f) begin
                e_err[d]  = m_busy[d];
                m_busy[d] = 1; m_idx[d] = 0; m_mode[d] = sb;
                m_a[d] = 64'd0; m_b[d] = 64'd0;
                proc = 1;
            end else if (!m_busy[d]) begin
                e_err[d] = 1;
            end else begin
                proc = 1;
            end
        end
        if (proc) begin
            m_a[d] = m_a[d] | (av << (m_idx[d] * dig));
            m_b[d] = m_b[d] | (bv << (m_idx[d] * dig));
            beff = m_mode[d] ? (~m_b[d] & mask) : m_b[d];
            r = m_a[d] + beff + {63'd0, m_mode[d]};
            e_valid[d] = 1;
            e_first[d] = (m_idx[d] == 0);
            e_sum[d]   = 4'((r >> (m_idx[d] * dig)) & dmask);
            m_idx[d]++;
            if (m_idx[d] == nd) begin
                sa  = m_a[d][w-1];
                sbb = m_b[d][w-1];
                sr  = r[w-1];
                e_last[d]  = 1;
                e_carry[d] = r[w];
                e_ovf[d]   = m_mode[d] ? (sa != sbb && sr != sa) : (sa == sbb && sr != sa);
                if (mn[d] < 64) mw[d][mn[d]] = 8'(r & mask);
                mn[d]++;
                m_busy[d] = 0;
                m_idx[d]  = 0;
            end
        end
    endtask

    // compare process: model advances on each edge, DUT sampled 1 time unit later
    initial begin
        logic [63:0] sv;
        forever begin
            @(posedge clk);
            model_step(0);
            model_step(1);
            #1;
            for (int d = 0; d < 2; d++) begin
                sv = (d == 0) ? {63'd0, sum0} : {60'd0, sum1};
                chk("out_valid", d, out_valid_d[d], e_valid[d]);
                chk("out_first", d, out_first_d[d], e_first[d]);
                chk("out_last",  d, out_last_d[d],  e_last[d]);
                chk("carry_out", d, carry_d[d],     e_carry[d]);
                chk("overflow",  d, ovf_d[d],       e_ovf[d]);
                chk("err",       d, err_d[d],       e_err[d]);
                if (e_valid[d]) chk("sum", d, sv, {60'd0, e_sum[d]});
                if (out_valid_d[d] === 1'b1) begin
                    if (out_first_d[d] === 1'b1) begin
                        acc[d] = 64'd0;
                        pos[d] = 0;
                    end
                    acc[d] = acc[d] | (sv << (pos[d] * dig_of(d)));
                    pos[d]++;
                    if (out_last_d[d] === 1'b1) begin
                        if (ln[d] < 64) begin
                            lw[d][ln[d]] = acc[d][7:0];
                            lc[d][ln[d]] = carry_d[d];
                            lo[d][ln[d]] = ovf_d[d];
                        end
                        ln[d]++;
                    end
                end
            end
        end
    end

    task automatic drive(input int d, input bit v, input bit f, input bit sb,
                         input logic [63:0] av, input logic [63:0] bv);
        in_valid_d[d] = v;
        in_first_d[d] = f;
        sub_d[d]      = sb;
        if (d == 0) begin
            a0 = av[0:0];
            b0 = bv[0:0];
        end else begin
            a1 = av[3:0];
            b1 = bv[3:0];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 64'd0, 64'd0);
            drive(1, 0, 0, 0, 64'd0, 64'd0);
        end
    endtask

    task automatic send(input int d, input logic [63:0] wa, input logic [63:0] wb, input bit sb,
                        input int ndig, input int stall_at, input int stall_len);
        int dig;
        logic [63:0] dmask;
        dig   = dig_of(d);
        dmask = (64'd1 << dig) - 64'd1;
        for (int i = 0; i < ndig; i++) begin
            @(negedge clk);
            drive(d, 1, (i == 0), sb, (wa >> (i * dig)) & dmask, (wb >> (i * dig)) & dmask);
            if (i == stall_at) begin
                repeat (stall_len) begin
                    @(negedge clk);
                    drive(d, 0, 0, 0, 64'd0, 64'd0);
                end
            end
        end
    endtask

    task automatic check_word(input int d, input int k, input logic [7:0] w, input bit c, input bit o);
        chk("word_dut", d, lw[d][k], w);
        chk("word_model", d, mw[d][k], w);
        chk("word_carry", d, lc[d][k], c);
        chk("word_ovf", d, lo[d][k], o);
    endtask

    initial begin
        int rpos [2];
        rst = 1'b1;
        ln[0] = 0; ln[1] = 0; mn[0] = 0; mn[1] = 0;
        pos[0] = 0; pos[1] = 0; acc[0] = 64'd0; acc[1] = 64'd0;
        drive(0, 0, 0, 0, 64'd0, 64'd0);
        drive(1, 0, 0, 0, 64'd0, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(1);

        send(0, 64'h5A, 64'h33, 1'b0, 8, -1, 0);
        idle(2);
        send(0, 64'h10, 64'h20, 1'b1, 8, -1, 0);
        send(0, 64'h7F, 64'hFF, 1'b1, 8, -1, 0);
        idle(2);
        send(0, 64'h33, 64'h11, 1'b0, 3, -1, 0);
        send(0, 64'h01, 64'h01, 1'b0, 8, -1, 0);
        idle(2);
        @(negedge clk);
        drive(0, 1, 0, 0, 64'd1, 64'd1);
        idle(1);
        send(0, 64'h00, 64'h00, 1'b0, 8, -1, 0);
        idle(2);
        send(0, 64'hC3, 64'h3C, 1'b0, 4, -1, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 64'd0, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        send(0, 64'hAA, 64'h55, 1'b0, 8, -1, 0);
        idle(2);

        send(1, 64'hFF, 64'h01, 1'b0, 2, -1, 0);
        idle(1);
        send(1, 64'hFF, 64'h01, 1'b0, 2, 0, 3);
        idle(3);

        chk("dut0_word_count", 0, ln[0], 6);
        chk("dut1_word_count", 1, ln[1], 2);
        check_word(0, 0, 8'h8D, 1'b0, 1'b1);
        check_word(0, 1, 8'hF0, 1'b0, 1'b0);
        check_word(0, 2, 8'h80, 1'b0, 1'b1);
        check_word(0, 3, 8'h02, 1'b0, 1'b0);
        check_word(0, 4, 8'h00, 1'b0, 1'b0);
        check_word(0, 5, 8'hFF, 1'b0, 1'b0);
        check_word(1, 0, 8'h00, 1'b1, 1'b0);
        check_word(1, 1, 8'h00, 1'b1, 1'b0);

        rpos[0] = 0;
        rpos[1] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            for (int d = 0; d < 2; d++) begin
                bit v, f;
                logic [63:0] dmask;
                dmask = (64'd1 << dig_of(d)) - 64'd1;
                v = ($urandom_range(0, 3) != 0);
                f = 0;
                if (v) begin
                    f = (rpos[d] == 0) ^ ($urandom_range(0, 24) == 0);
                    if (f) rpos[d] = 1;
                    else   rpos[d] = rpos[d] + 1;
                    if (rpos[d] >= nd_of(d)) rpos[d] = 0;
                end
                if (rst) rpos[d] = 0;
                drive(d, v, f, $urandom_range(0, 1) == 1,
                      64'($urandom) & dmask, 64'($urandom) & dmask);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
